// File: rtl/sequence_generator.sv
// ----------------------------------------------------------------------------
// sequence_generator
//
// Serial pattern transmitter. Emits a fixed PAT_LEN-bit PATTERN, MSB first,
// one bit per clk. The pattern is repeated rep_count times (0 counts as 1),
// optionally separated by gap_cycles idle cycles. Used to drive the serial
// input of the on-chip sequence detector for stimulus and loopback self-test.
//
// Optional feature (macro SEQ_GEN_ERR_INJECT_EN):
//   adds input inject_err; when high in a cycle whose next output is a
//   pattern bit, that one bit is transmitted inverted. Sequencing of state,
//   bit_idx and the repeat counter is not affected.
//
// Ports:
//   clk         in   1      clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   start       in   1      start request, sampled only in IDLE
//   abort       in   1      synchronous cancel of the current transfer
//   rep_count   in   CNT_W  number of repeats (0 treated as 1), latched at start
//   gap_cycles  in   GAP_W  idle cycles between repeats, latched at start
//   inject_err  in   1      (SEQ_GEN_ERR_INJECT_EN only) invert next pattern bit
//   out         out  1      serial data bit, registered
//   out_valid   out  1      out carries a pattern bit this cycle
//   busy        out  1      transfer in progress (SHIFT or GAP)
//   done        out  1      one-cycle pulse after the last bit of the last repeat
//   state       out  3      FSM state for debug (IDLE=0, SHIFT=1, GAP=2, DONE=3)
//   bit_idx     out  5      index of the bit currently on out
// ----------------------------------------------------------------------------
module sequence_generator #(
    parameter int                  PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0]  PATTERN = 6'b101011,
    parameter int                  CNT_W   = 8,
    parameter int                  GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_cycles,
`ifdef SEQ_GEN_ERR_INJECT_EN
    input  logic             inject_err,
`endif
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state,
    output logic [4:0]       bit_idx
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SHIFT = 3'b001,
        ST_GAP   = 3'b010,
        ST_DONE  = 3'b011
    } state_e;

    localparam logic [4:0] MSB_IDX = 5'(PAT_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rep_q, rep_d;        // repeats still to transmit
    logic [GAP_W-1:0]   gap_len_q, gap_len_d; // latched gap length
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d; // gap cycles remaining after this one
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               emit;      // next cycle carries a pattern bit
    logic               flip;      // invert the next pattern bit
    logic [CNT_W-1:0]   rep_left;  // repeats left once the current one completes
    logic [PAT_LEN-1:0] pat_shift;

`ifdef SEQ_GEN_ERR_INJECT_EN
    assign flip = inject_err;
`else
    assign flip = 1'b0;
`endif

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        rep_d       = rep_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        bit_idx_d   = 5'd0;
        emit        = 1'b0;
        rep_left    = rep_q - CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                // abort wins over start; on its own abort is a no-op here
                if (start && !abort) begin
                    rep_d     = (rep_count == '0) ? CNT_W'(1) : rep_count;
                    gap_len_d = gap_cycles;
                    state_d   = ST_SHIFT;
                    bit_idx_d = MSB_IDX;
                    emit      = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rep_d   = '0;
                end else if (bit_idx_q != 5'd0) begin
                    bit_idx_d = bit_idx_q - 5'd1;
                    emit      = 1'b1;
                end else begin
                    // last bit of this repeat is on out now
                    rep_d = rep_left;
                    if (rep_left == '0) begin
                        state_d = ST_DONE;
                    end else if (gap_len_q == '0) begin
                        bit_idx_d = MSB_IDX;  // back-to-back, no bubble
                        emit      = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_len_q - GAP_W'(1);
                    end
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rep_d   = '0;
                end else if (gap_cnt_q == '0) begin
                    state_d   = ST_SHIFT;
                    bit_idx_d = MSB_IDX;
                    emit      = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                // unreachable encodings recover to IDLE
                state_d = ST_IDLE;
                rep_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so they can be registered
        // alongside it, keeping inputs off any combinational output path.
        pat_shift   = PATTERN >> bit_idx_d;
        out_valid_d = emit;
        out_d       = emit & (pat_shift[0] ^ flip);
        busy_d      = (state_d == ST_SHIFT) || (state_d == ST_GAP);
        done_d      = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rep_q       <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            bit_idx_q   <= 5'd0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_idx_q   <= bit_idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state     = state_q;
    assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_sequence_generator.sv
// ----------------------------------------------------------------------------
// tb_sequence_generator
//
// Self-checking bench for sequence_generator. For each transfer a list of the
// expected per-cycle outputs is built directly from the transmit rules
// (repeats of the pattern, gaps between them, a done cycle at the end), then
// the DUT outputs are compared against it cycle by cycle on the falling edge.
// ----------------------------------------------------------------------------
module tb_sequence_generator;

    localparam int          PAT_LEN = 6;
    localparam logic [5:0]  PATTERN = 6'b101011;

    // record layout: {out, out_valid, busy, done, state[2:0], bit_idx[4:0]}
    localparam logic [11:0] REC_IDLE = 12'b0_0_0_0_000_00000;
    localparam logic [11:0] REC_GAP  = 12'b0_0_1_0_010_00000;
    localparam logic [11:0] REC_DONE = 12'b0_0_0_1_011_00000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] rep_count = 8'd0;
    logic [3:0] gap_cycles = 4'd0;
`ifdef SEQ_GEN_ERR_INJECT_EN
    logic       inject_err = 1'b0;
`endif
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [2:0] state;
    logic [4:0] bit_idx;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    logic        inj = 1'b0;

    sequence_generator dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .rep_count  (rep_count),
        .gap_cycles (gap_cycles),
`ifdef SEQ_GEN_ERR_INJECT_EN
        .inject_err (inject_err),
`endif
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .state      (state),
        .bit_idx    (bit_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {out, out_valid, busy, done, state, bit_idx};
    endfunction

    function automatic logic [11:0] rec_bit(input int i);
        logic [5:0] sh;
        sh = PATTERN >> i;
        return {sh[0], 1'b1, 1'b1, 1'b0, 3'b001, 5'(i)};
    endfunction

    // Expected output of every cycle after start is accepted.
    function automatic void build(input int reps, input int gap);
        int eff;
        eff = (reps == 0) ? 1 : reps;
        exp_q.delete();
        for (int r = 0; r < eff; r++) begin
            for (int i = PAT_LEN - 1; i >= 0; i--) exp_q.push_back(rec_bit(i));
            if (r != eff - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(REC_GAP);
        end
        exp_q.push_back(REC_DONE);
    endfunction

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] expv);
        n_cmp++;
        assert (act === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, act, expv);
        end
    endtask

    task automatic drive_inject(input logic v);
        inj = v;
`ifdef SEQ_GEN_ERR_INJECT_EN
        inject_err = v;
`endif
    endtask

    function automatic logic rand_inject();
`ifdef SEQ_GEN_ERR_INJECT_EN
        return ($urandom_range(0, 5) == 0);
`else
        return 1'b0;
`endif
    endfunction

    // One transfer. abort_at = index of the expected cycle after which abort
    // is raised (-1: never). noise = toggle start and scramble the config
    // inputs while busy; neither may affect the running transfer.
    task automatic run_xfer(input string tag, input int reps, input int gap,
                            input int abort_at, input bit noise);
        logic [11:0] e;
        bit          aborted;
        aborted = 1'b0;
        build(reps, gap);
        @(negedge clk);
        check({tag, ":pre_idle"}, obs(), REC_IDLE);
        start      = 1'b1;
        rep_count  = reps[7:0];
        gap_cycles = gap[3:0];
        drive_inject(rand_inject());
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            e = exp_q[k];
            if (inj && e[10]) e[11] = ~e[11];
            check($sformatf("%s:c%0d", tag, k + 1), obs(), e);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                rep_count  = 8'($urandom);
                gap_cycles = 4'($urandom);
            end
            drive_inject(rand_inject());
            if (k == abort_at) begin
                abort = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        drive_inject(1'b0);
        check({tag, aborted ? ":abort_idle" : ":post_idle"}, obs(), REC_IDLE);
    endtask

    initial begin
        // reset state, held asynchronously from time zero
        #3;
        check("reset_state", obs(), REC_IDLE);
        @(negedge clk);
        reset = 1'b1;

        run_xfer("s1_single",      1, 0, -1, 1'b0);
        run_xfer("s2_b2b",         2, 0, -1, 1'b0);
        run_xfer("s3_gap3",        2, 3, -1, 1'b0);
        run_xfer("s4_rep0",        0, 0, -1, 1'b0);
        run_xfer("s5_abort_bit3",  3, 2,  2, 1'b0);
        run_xfer("s5_restart",     1, 0, -1, 1'b0);
        run_xfer("gap_max",        2, 15, -1, 1'b0);
        run_xfer("abort_in_gap",   3, 4,  7, 1'b0);
        run_xfer("noise",          3, 1, -1, 1'b1);
        run_xfer("rep_max",      255, 0, -1, 1'b0);

        // s6: reset mid-GAP clears outputs without waiting for a clock edge
        @(negedge clk);
        start      = 1'b1;
        rep_count  = 8'd2;
        gap_cycles = 4'd3;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("s6_in_gap", obs(), REC_GAP);
        #1 reset = 1'b0;
        #1 check("s6_async_reset", obs(), REC_IDLE);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("s6_idle_after", obs(), REC_IDLE);

        // randomized transfers
        for (int t = 0; t < 40; t++) begin
            int reps, gap, ab;
            reps = $urandom_range(0, 4);
            gap  = $urandom_range(0, 4);
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_xfer($sformatf("rnd%0d", t), reps, gap, ab, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
